// File: rtl/rcb_mac_pkg.sv
// Shared types and constants for the signed-digit MAC sequencer.
package rcb_mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int unsigned DIGIT_W = 2;
  localparam int unsigned PROD_W  = 5;

endpackage

// File: rtl/rcb_digit_mul_cell.sv
// 2-bit signed-digit approximate product cell; bit-exact, intentionally not a true multiplier.
module rcb_digit_mul_cell
  import rcb_mac_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_a,
  input  logic [DIGIT_W-1:0] d_b,
  input  logic               sx,
  input  logic               sy,
  output logic [PROD_W-1:0]  p
);

  logic [2:0] x, y;
  logic       w;

  always_comb begin
    x = {sx & d_a[1], d_a};
    y = {sy & d_b[1], d_b};
    // Both digits equal to 2 -> the 4 term
    w = (x[1] & ~x[0]) & (y[1] & ~y[0]);
    p[0] = x[0] & y[0];
    p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    p[4] = (x[2] ^ y[2]) & (x[1] | x[0]) & (y[1] | y[0]);
    p[3] = p[4];
    p[2] = w ^ p[4];
  end

endmodule

// File: rtl/rcb_digit_mac_seq.sv
// Digit-serial shift-accumulate MAC around rcb_digit_mul_cell.
// Define RCB_MAC_SAT_EN for saturating accumulation and the sat_flag output.
module rcb_digit_mac_seq
  import rcb_mac_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic             signed_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
`ifdef RCB_MAC_SAT_EN
  output logic             sat_flag,
`endif
  output logic             busy
);

  localparam int unsigned N   = W / DIGIT_W;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SHW = CW + 2;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e             state_q;
  logic [W-1:0]       a_q, b_q;
  logic               sm_q;
  logic [CW-1:0]      i_q, j_q;
  logic [ACC_W-1:0]   acc_q, acc_d, pp;
  logic [DIGIT_W-1:0] d_a, d_b;
  logic               sx, sy;
  logic [PROD_W-1:0]  p;
  logic [SHW-1:0]     shamt;
  logic               in_ready_q, out_valid_q, busy_q;
`ifdef RCB_MAC_SAT_EN
  logic [ACC_W:0]     sum_x;
  logic               ovf;
  logic               sat_q;
`endif

  always_comb begin
    d_a   = a_q[{i_q, 1'b0} +: DIGIT_W];
    d_b   = b_q[{j_q, 1'b0} +: DIGIT_W];
    sx    = sm_q & (i_q == LAST);
    sy    = sm_q & (j_q == LAST);
    shamt = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
  end

  rcb_digit_mul_cell u_cell (
    .d_a (d_a),
    .d_b (d_b),
    .sx  (sx),
    .sy  (sy),
    .p   (p)
  );

  always_comb begin
    pp = {{(ACC_W - PROD_W){p[PROD_W-1]}}, p} << shamt;
`ifdef RCB_MAC_SAT_EN
    // One guard bit: overflow when it disagrees with the result sign
    sum_x = {acc_q[ACC_W-1], acc_q} + {pp[ACC_W-1], pp};
    ovf   = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    if (!ovf) begin
      acc_d = sum_x[ACC_W-1:0];
    end else if (sum_x[ACC_W]) begin
      acc_d = {1'b1, {(ACC_W - 1){1'b0}}};
    end else begin
      acc_d = {1'b0, {(ACC_W - 1){1'b1}}};
    end
`else
    acc_d = acc_q + pp;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sm_q        <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RCB_MAC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= op_a;
            b_q        <= op_b;
            sm_q       <= signed_mode;
            i_q        <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
            if (acc_clr) begin
              acc_q <= '0;
`ifdef RCB_MAC_SAT_EN
              sat_q <= 1'b0;
`endif
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_d;
`ifdef RCB_MAC_SAT_EN
          if (ovf) sat_q <= 1'b1;
`endif
          if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;
`ifdef RCB_MAC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_rcb_digit_mac_seq.sv
// Directed bench: ACC_W=20 main instance plus an ACC_W=16 instance for wrap/saturation.
module tb_rcb_digit_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, signed_mode, acc_clr, out_ready;
  logic [7:0]  op_a, op_b;
  logic        in_ready, out_valid, busy;
  logic [19:0] result;
  logic        in_ready16, out_valid16, busy16;
  logic [15:0] result16;
`ifdef RCB_MAC_SAT_EN
  logic        sat_flag, sat_flag16;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  logic hold_ok, quiet_ok;

  always #5 clk = ~clk;

  rcb_digit_mac_seq #(.W(8), .ACC_W(20)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .signed_mode (signed_mode),
    .acc_clr     (acc_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
`ifdef RCB_MAC_SAT_EN
    .sat_flag    (sat_flag),
`endif
    .busy        (busy)
  );

  rcb_digit_mac_seq #(.W(8), .ACC_W(16)) u_dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready16),
    .op_a        (op_a),
    .op_b        (op_b),
    .signed_mode (signed_mode),
    .acc_clr     (acc_clr),
    .out_valid   (out_valid16),
    .out_ready   (out_ready),
    .result      (result16),
`ifdef RCB_MAC_SAT_EN
    .sat_flag    (sat_flag16),
`endif
    .busy        (busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge in IDLE; returns cycles from the accept cycle to out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic clr, output int cycles);
    op_a = a; op_b = b; signed_mode = sm; acc_clr = clr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    check("busy_in_run", {31'd0, busy}, 32'd1);
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; signed_mode = 1'b0; acc_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("rel_result", {12'd0, result}, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);

    // Unsigned 0x12*0x21 = 0x252
    run_op(8'h12, 8'h21, 1'b0, 1'b1, lat);
    check("u_latency", lat, 32'd17);
    check("u_result", {12'd0, result}, 32'h252);
    check("u_in_ready_done", {31'd0, in_ready}, 32'd0);
    check("u_busy_done", {31'd0, busy}, 32'd0);
    take();
    check("u_in_ready_idle", {31'd0, in_ready}, 32'd1);

    // Accumulate 0x02*0x02 on top
    run_op(8'h02, 8'h02, 1'b0, 1'b0, lat);
    check("mac_result", {12'd0, result}, 32'h256);
    take();

    // Signed top digit -2: 0x80*0x01 = -128
    run_op(8'h80, 8'h01, 1'b1, 1'b1, lat);
    check("s_latency", lat, 32'd17);
    check("s_result", {12'd0, result}, 32'hFFF80);

    // Backpressure: result held, new operands ignored
    hold_ok = 1'b1;
    op_a = 8'hFF; op_b = 8'hFF; acc_clr = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (result !== 20'hFFF80 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
        hold_ok = 1'b0;
    end
    check("bp_hold", {31'd0, hold_ok}, 32'd1);
    check("bp_result", {12'd0, result}, 32'hFFF80);
    in_valid = 1'b0;
    take();
    repeat (3) @(negedge clk);
    check("bp_not_queued_ov", {31'd0, out_valid}, 32'd0);
    check("bp_not_queued_busy", {31'd0, busy}, 32'd0);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);

    // Add 1*1 onto held -128
    run_op(8'h01, 8'h01, 1'b0, 1'b0, lat);
    check("neg_mac_result", {12'd0, result}, 32'hFFF81);
    take();

    // Reset in the middle of a run
    op_a = 8'h12; op_b = 8'h21; signed_mode = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", {12'd0, result}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    quiet_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
    end
    check("mid_aborted", {31'd0, quiet_ok}, 32'd1);

    // 0x7A*0x6A under the cell function = 11588 (0x2D44); three accumulations
    run_op(8'h7A, 8'h6A, 1'b0, 1'b1, lat);
    check("acc1_r16", {16'd0, result16}, 32'h2D44);
    take();
    run_op(8'h7A, 8'h6A, 1'b0, 1'b0, lat);
    check("acc2_r16", {16'd0, result16}, 32'h5A88);
`ifdef RCB_MAC_SAT_EN
    check("acc2_sat16", {31'd0, sat_flag16}, 32'd0);
`endif
    take();
    run_op(8'h7A, 8'h6A, 1'b0, 1'b0, lat);
    check("acc3_r20", {12'd0, result}, 32'h87CC);
`ifdef RCB_MAC_SAT_EN
    check("acc3_r16_sat", {16'd0, result16}, 32'h7FFF);
    check("acc3_sat16", {31'd0, sat_flag16}, 32'd1);
    check("acc3_sat20", {31'd0, sat_flag}, 32'd0);
`else
    check("acc3_r16_wrap", {16'd0, result16}, 32'h87CC);
`endif
    take();
    run_op(8'h01, 8'h01, 1'b0, 1'b1, lat);
    check("clr_r16", {16'd0, result16}, 32'h1);
`ifdef RCB_MAC_SAT_EN
    check("clr_sat16", {31'd0, sat_flag16}, 32'd0);
`endif
    take();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
